// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size modes, Nk/Nr lookup, Rcon,
// RotWord and the scheduler FSM state type.
package aes_pkg;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;

  typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_t;

  // Key length in 32-bit words; the unused encoding 2'b11 behaves as 128-bit.
  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      MODE_192: return 4'd6;
      MODE_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      MODE_192: return 4'd12;
      MODE_256: return 4'd14;
      default:  return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one substituted byte out.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// Decrypt-side round-key generator: expands forward through an Nk-word window,
// then walks the schedule backward emitting round keys Nr..0 on a valid/ready stream.
module aes_inv_key_scheduler
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  state_t state, state_nxt;

  logic [1:0]       mode_q;
  logic [7:0][31:0] win, win_nxt;   // win[k] = w[base+k]
  logic [5:0]       base;
  logic [2:0]       pos;            // word index mod Nk (i in FWD, j in BWD)
  logic [3:0]       quo;            // word index div Nk
  logic [3:0]       rnd;            // next round key to load
  logic             all_loaded;

  logic [3:0]   nk, nr, nk_in;
  logic [2:0]   hi_idx, hi2_idx, off;
  logic [5:0]   key_pos;
  logic         key_here, out_free, accept, fwd_last, fwd_step, bwd_step, load_key;
  logic [255:0] key_al;
  logic [31:0]  src, other, sbox_in, sub, temp, new_word;

  assign nk       = nk_of(mode_q);
  assign nr       = nr_of(mode_q);
  assign nk_in    = nk_of(mode);
  assign hi_idx   = nk[2:0] - 3'd1;
  assign hi2_idx  = nk[2:0] - 3'd2;
  assign fwd_last = base == ({nr, 2'b00} + 6'd3 - {2'b00, nk});
  assign key_pos  = {rnd, 2'b00};
  assign key_here = key_pos >= base;
  assign off      = key_pos[2:0] - base[2:0];
  assign out_free = !rk_valid || rk_ready;
  assign accept   = rk_valid && rk_ready;
  assign fwd_step = state == FWD;
  assign bwd_step = (state == BWD) && !all_loaded && !key_here;
  assign load_key = (state == BWD) && !all_loaded && key_here && out_free;
  assign busy     = (state == FWD) || (state == BWD);

  // Backward recovers w[j-Nk] = w[j] ^ f(w[j-1]), reusing the forward f().
  assign src     = fwd_step ? win[hi_idx] : win[hi2_idx];
  assign other   = fwd_step ? win[0] : win[hi_idx];
  assign sbox_in = (pos == 3'd0) ? rot_word(src) : src;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sbox_in[8*g +: 8]), .y(sub[8*g +: 8]));
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    temp = src;
    if (pos == 3'd0)
      temp = sub ^ {rcon(quo), 24'h0};
    else if (nk == 4'd8 && pos == 3'd4)
      temp = sub;
  end

  assign new_word = other ^ temp;

  always_comb begin
    case (nk_in)
      4'd6:    key_al = {key[191:0], 64'h0};
      4'd8:    key_al = key;
      default: key_al = {key[127:0], 128'h0};
    endcase
  end

  always_comb begin
    win_nxt = win;
    if (state == IDLE && start) begin
      for (int k = 0; k < 8; k++) win_nxt[k] = key_al[255-32*k -: 32];
    end else if (fwd_step) begin
      win_nxt         = win >> 32;
      win_nxt[hi_idx] = new_word;
    end else if (bwd_step) begin
      win_nxt    = win << 32;
      win_nxt[0] = new_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FWD;
      FWD:     if (fwd_last) state_nxt = BWD;
      BWD:     if (accept && rk_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the window is a small register bank, so it is cleared with everything else.
      win        <= '0;
      mode_q     <= MODE_128;
      base       <= '0;
      pos        <= '0;
      quo        <= '0;
      rnd        <= '0;
      all_loaded <= 1'b0;
      rk_valid   <= 1'b0;
      rk         <= '0;
      rk_round   <= '0;
      rk_last    <= 1'b0;
    end else begin
      win <= win_nxt;
      if (state == IDLE && start) begin
        mode_q     <= (nk_in == 4'd4) ? MODE_128 : mode;
        base       <= '0;
        pos        <= '0;
        quo        <= 4'd1;
        all_loaded <= 1'b0;
      end
      if (fwd_step) begin
        base <= base + 6'd1;
        // The final forward index doubles as the first backward index.
        if (fwd_last) begin
          rnd <= nr;
        end else if (pos == hi_idx) begin
          pos <= '0;
          quo <= quo + 4'd1;
        end else begin
          pos <= pos + 3'd1;
        end
      end
      if (bwd_step) begin
        base <= base - 6'd1;
        if (pos == 3'd0) begin
          pos <= hi_idx;
          quo <= quo - 4'd1;
        end else begin
          pos <= pos - 3'd1;
        end
      end
      if (load_key) begin
        rk       <= {win[off], win[off + 3'd1], win[off + 3'd2], win[off + 3'd3]};
        rk_valid <= 1'b1;
        rk_round <= rnd;
        rk_last  <= (rnd == 4'd0);
        if (rnd == 4'd0) all_loaded <= 1'b1;
        else             rnd <= rnd - 4'd1;
      end else if (accept) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule
